axis_trigger_sequencer: RTL and testbench

//  Arms, qualifies and sequences a level-crossing capture on a signed ADC AXI-Stream.

---
 rtl/trig_seq_pkg.sv | 17 +
 rtl/axis_hyst_cross.sv | 62 ++++++
 rtl/axis_trigger_sequencer.sv | 155 +++++++++++++++
 tb/tb_axis_trigger_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_seq_pkg.sv
// Shared constants for the AXI-Stream trigger sequencer.
//   ST_*  : FSM state encodings (also reported on state_out)
//   DIR_* : crossing direction selects for cfg_direction
package trig_seq_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_PRE     = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT    = 3'd2;
  localparam logic [ST_W-1:0] ST_POST    = 3'd3;
  localparam logic [ST_W-1:0] ST_HOLDOFF = 3'd4;

  localparam logic DIR_RISING  = 1'b0;
  localparam logic DIR_FALLING = 1'b1;

endpackage

// File: rtl/axis_hyst_cross.sv
// Hysteresis-qualified level-crossing detector.
//   aclk, aresetn : clock, synchronous active-low reset
//   sample, valid : signed input sample and its valid
//   level, hyst   : signed trigger level, unsigned hysteresis band
//   direction     : DIR_RISING / DIR_FALLING
//   clear         : FSM is entering WAIT; drop qualification unless this sample re-qualifies
//   cross_c       : combinational, valid qualified sample beyond the level
module axis_hyst_cross
  import trig_seq_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [W-1:0] sample,
  input  logic         valid,
  input  logic [W-1:0] level,
  input  logic [W-1:0] hyst,
  input  logic         direction,
  input  logic         clear,
  output logic         cross_c
);

  localparam int unsigned XW = W + 2;

  // Two guard bits so level +/- hyst never wraps.
  logic signed [XW-1:0] sample_x, level_x, hyst_x, lo_x, hi_x;
  logic                 beyond_c, over_c, qual;

  assign sample_x = {{2{sample[W-1]}}, sample};
  assign level_x  = {{2{level[W-1]}}, level};
  assign hyst_x   = {2'b00, hyst};
  assign lo_x     = level_x - hyst_x;
  assign hi_x     = level_x + hyst_x;

  // beyond_c: sample on the arming side of the band; over_c: sample past the level.
  always_comb begin
    beyond_c = 1'b0;
    over_c   = 1'b0;
    if (direction == DIR_FALLING) begin
      beyond_c = (sample_x > hi_x);
      over_c   = (sample_x < level_x);
    end else begin
      beyond_c = (sample_x < lo_x);
      over_c   = (sample_x > level_x);
    end
  end

  // Qualification flag; a re-qualifying sample wins over the clear.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      qual <= 1'b0;
    end else if (valid && beyond_c) begin
      qual <= 1'b1;
    end else if (clear) begin
      qual <= 1'b0;
    end
  end

  assign cross_c = valid & qual & over_c;

endmodule

// File: rtl/axis_trigger_sequencer.sv
// Arms, qualifies and sequences a level-crossing capture on a signed ADC stream.
//   aclk, aresetn        : clock, synchronous active-low reset
//   s_axis_*             : input stream (never stalled)
//   m_axis_*             : passthrough stream, tvalid gated to the capture window
//   cfg_*                : trigger level/hysteresis/direction, pre/post/holdoff counts, auto re-arm
//   arm, abort, force_trig : control strobes
//   trig_pulse, busy, done, state_out, trig_count : status
module axis_trigger_sequencer
  import trig_seq_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH        = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_level,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_hyst,
  input  logic                        cfg_direction,
  input  logic [CNT_WIDTH-1:0]        cfg_pre,
  input  logic [CNT_WIDTH-1:0]        cfg_post,
  input  logic [CNT_WIDTH-1:0]        cfg_holdoff,
  input  logic                        cfg_auto,
  input  logic                        arm,
  input  logic                        abort,
  input  logic                        force_trig,
  output logic                        trig_pulse,
  output logic                        busy,
  output logic                        done,
  output logic [2:0]                  state_out,
  output logic [CNT_WIDTH-1:0]        trig_count
);

  logic [ST_W-1:0]      state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 arm_d, arm_rise_c, done_nxt, pulse_nxt;
  logic                 pre_done_c, enter_wait_c, cross_c, trig_c, window_c;

  assign s_axis_tready = 1'b1;
  assign m_axis_tdata  = s_axis_tdata;
  assign window_c      = (state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST);
  assign m_axis_tvalid = s_axis_tvalid & window_c;
  assign state_out     = state;

  assign arm_rise_c   = arm & ~arm_d;
  assign pre_done_c   = (cfg_pre == '0) || (s_axis_tvalid && (cnt == cfg_pre - CNT_WIDTH'(1)));
  assign enter_wait_c = (state == ST_PRE) && pre_done_c && !abort;
  assign trig_c       = (state == ST_WAIT) && (force_trig || cross_c);

  axis_hyst_cross #(.W(AXIS_TDATA_WIDTH)) u_cross (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .sample    (s_axis_tdata),
    .valid     (s_axis_tvalid),
    .level     (cfg_level),
    .hyst      (cfg_hyst),
    .direction (cfg_direction),
    .clear     (enter_wait_c),
    .cross_c   (cross_c)
  );

  // Next-state logic; one counter is reused by PRE, POST and HOLDOFF.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = done;
    pulse_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm_rise_c) begin
          state_nxt = ST_PRE;
          cnt_nxt   = '0;
          done_nxt  = 1'b0;
        end
      end
      ST_PRE: begin
        if (pre_done_c) begin
          state_nxt = ST_WAIT;
        end else if (s_axis_tvalid) begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      ST_WAIT: begin
        if (trig_c) begin
          pulse_nxt = 1'b1;
          cnt_nxt   = '0;
          if (cfg_post == '0) begin
            state_nxt = ST_HOLDOFF;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_POST;
          end
        end
      end
      ST_POST: begin
        if (s_axis_tvalid) begin
          if (cnt == cfg_post - CNT_WIDTH'(1)) begin
            state_nxt = ST_HOLDOFF;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
          end
        end
      end
      ST_HOLDOFF: begin
        if (cnt == cfg_holdoff) begin
          state_nxt = cfg_auto ? ST_PRE : ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Abort overrides everything, leaving done as it was.
    if (abort) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      done_nxt  = done;
      pulse_nxt = 1'b0;
    end
  end

  // State and status registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      arm_d      <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      trig_pulse <= 1'b0;
      trig_count <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      arm_d      <= arm;
      done       <= done_nxt;
      busy       <= (state_nxt != ST_IDLE);
      trig_pulse <= pulse_nxt;
      if (pulse_nxt) begin
        trig_count <= trig_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_trigger_sequencer.sv
// Self-checking bench for axis_trigger_sequencer: a per-cycle vector table plus
// directed multi-cycle sequences; trigger samples go through a scoreboard queue.
module tb_axis_trigger_sequencer;
  import trig_seq_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned C = 32;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [W-1:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic [W-1:0] cfg_level, cfg_hyst;
  logic         cfg_direction, cfg_auto;
  logic [C-1:0] cfg_pre, cfg_post, cfg_holdoff;
  logic         arm, abort, force_trig;
  logic         trig_pulse, busy, done;
  logic [2:0]   state_out;
  logic [C-1:0] trig_count;

  axis_trigger_sequencer #(.AXIS_TDATA_WIDTH(W), .CNT_WIDTH(C)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .cfg_level(cfg_level), .cfg_hyst(cfg_hyst), .cfg_direction(cfg_direction),
    .cfg_pre(cfg_pre), .cfg_post(cfg_post), .cfg_holdoff(cfg_holdoff), .cfg_auto(cfg_auto),
    .arm(arm), .abort(abort), .force_trig(force_trig),
    .trig_pulse(trig_pulse), .busy(busy), .done(done),
    .state_out(state_out), .trig_count(trig_count)
  );

  always #5 aclk = ~aclk;

  int passed = 0;
  int total  = 0;
  int exp_q[$];
  int exp_tc = 0;
  int prev_tdata = 0;
  int valid_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic expect_trig(input int d);
    exp_q.push_back(d);
    exp_tc++;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic samp(input logic v, input int d);
    s_axis_tvalid = v;
    s_axis_tdata  = W'(d);
    tick();
  endtask

  task automatic arm_pulse();
    s_axis_tvalid = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic set_cfg(input int lvl, input int hy, input logic dir, input int pre,
                         input int post, input int hold, input logic au);
    cfg_level = W'(lvl); cfg_hyst = W'(hy); cfg_direction = dir;
    cfg_pre = C'(pre); cfg_post = C'(post); cfg_holdoff = C'(hold); cfg_auto = au;
  endtask

  // Monitor: the trigger sample is the one presented the cycle before trig_pulse.
  always @(negedge aclk) begin
    if (m_axis_tvalid) begin
      valid_cnt++;
      check("m_tdata_passthrough", m_axis_tdata, s_axis_tdata);
    end
    if (trig_pulse) begin
      if (exp_q.size() == 0) check("unexpected_trig_pulse", 1, 0);
      else check("trig_sample", prev_tdata, exp_q.pop_front());
    end
    prev_tdata = int'($signed(s_axis_tdata));
  end

  typedef struct {
    logic       arm;
    logic       v;
    int         d;
    logic       frc;
    logic       abt;
    logic       mval;
    logic [2:0] st;
    logic       pls;
    logic       dn;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic v, input int d, input logic f,
                              input logic ab, input logic mv, input logic [2:0] st,
                              input logic p, input logic dn);
    vec_t r;
    r.arm = a; r.v = v; r.d = d; r.frc = f; r.abt = ab;
    r.mval = mv; r.st = st; r.pls = p; r.dn = dn;
    return r;
  endfunction

  vec_t tbl[22];

  initial begin
    int run, first_run, hold_total;
    int t6[8];

    aresetn = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b1;
    arm = 1'b0; abort = 1'b0; force_trig = 1'b0;
    set_cfg(100, 10, DIR_RISING, 2, 3, 1, 1'b0);
    repeat (3) tick();
    check("rst_state", state_out, ST_IDLE);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pulse", trig_pulse, 0);
    check("rst_count", trig_count, 0);
    check("rst_mvalid", m_axis_tvalid, 0);
    check("tready", s_axis_tready, 1);
    aresetn = 1'b1;
    s_axis_tvalid = 1'b0;
    tick();

    // Per-cycle table: arm, valid, data, force, abort | m_valid (before edge), state/pulse/done (after)
    tbl[0]  = mk(1, 0,   0, 0, 0, 0, ST_PRE,     0, 0);
    tbl[1]  = mk(1, 1,   0, 0, 0, 1, ST_PRE,     0, 0);
    tbl[2]  = mk(0, 0,   0, 0, 0, 0, ST_PRE,     0, 0);
    tbl[3]  = mk(0, 1,   0, 0, 0, 1, ST_WAIT,    0, 0);
    tbl[4]  = mk(0, 0,   7, 1, 0, 0, ST_POST,    1, 0);
    tbl[5]  = mk(0, 1,  50, 0, 0, 1, ST_POST,    0, 0);
    tbl[6]  = mk(0, 1,  50, 0, 1, 1, ST_IDLE,    0, 0);
    tbl[7]  = mk(0, 1, 200, 0, 0, 0, ST_IDLE,    0, 0);
    tbl[8]  = mk(1, 0,   0, 0, 0, 0, ST_PRE,     0, 0);
    tbl[9]  = mk(0, 1,  95, 0, 0, 1, ST_PRE,     0, 0);
    tbl[10] = mk(0, 1,  95, 0, 0, 1, ST_WAIT,    0, 0);
    tbl[11] = mk(1, 1, 150, 0, 0, 1, ST_WAIT,    0, 0);
    tbl[12] = mk(0, 1,  80, 0, 0, 1, ST_WAIT,    0, 0);
    tbl[13] = mk(0, 1, 101, 0, 0, 1, ST_POST,    1, 0);
    tbl[14] = mk(0, 1,   0, 0, 0, 1, ST_POST,    0, 0);
    tbl[15] = mk(0, 0,   0, 0, 0, 0, ST_POST,    0, 0);
    tbl[16] = mk(0, 1,   0, 0, 0, 1, ST_POST,    0, 0);
    tbl[17] = mk(0, 1,   0, 0, 0, 1, ST_HOLDOFF, 0, 1);
    tbl[18] = mk(0, 1,   0, 0, 0, 0, ST_HOLDOFF, 0, 1);
    tbl[19] = mk(0, 0,   0, 0, 0, 0, ST_IDLE,    0, 1);
    tbl[20] = mk(1, 0,   0, 0, 0, 0, ST_PRE,     0, 0);
    tbl[21] = mk(0, 1,   0, 0, 1, 1, ST_IDLE,    0, 0);

    for (int i = 0; i < 22; i++) begin
      arm = tbl[i].arm; s_axis_tvalid = tbl[i].v; s_axis_tdata = W'(tbl[i].d);
      force_trig = tbl[i].frc; abort = tbl[i].abt;
      if (tbl[i].pls) expect_trig(tbl[i].d);
      #2;
      check($sformatf("tbl%0d_mvalid", i), m_axis_tvalid, tbl[i].mval);
      tick();
      check($sformatf("tbl%0d_state", i), state_out, tbl[i].st);
      check($sformatf("tbl%0d_pulse", i), trig_pulse, tbl[i].pls);
      check($sformatf("tbl%0d_done", i), done, tbl[i].dn);
    end
    arm = 1'b0; abort = 1'b0; force_trig = 1'b0;
    check("tbl_trig_count", trig_count, exp_tc);

    // Rising ramp: 4 PRE + 28 WAIT (through 105) + 8 POST samples in the window.
    set_cfg(100, 10, DIR_RISING, 4, 8, 0, 1'b0);
    arm_pulse();
    valid_cnt = 0;
    expect_trig(105);
    for (int v = -50; v <= 200; v += 5) samp(1'b1, v);
    samp(1'b0, 0);
    check("ramp_valid_outputs", valid_cnt, 40);
    check("ramp_done", done, 1);
    check("ramp_state", state_out, ST_IDLE);
    check("ramp_trig_count", trig_count, exp_tc);

    // Noise around the level: one trigger, no re-trigger until a dip below level-hyst.
    set_cfg(100, 10, DIR_RISING, 1, 2, 0, 1'b0);
    arm_pulse();
    samp(1'b1, 80);
    samp(1'b1, 95);
    expect_trig(105);
    samp(1'b1, 105);
    for (int i = 0; i < 12; i++) samp(1'b1, (i % 2 == 0) ? 95 : 105);
    check("noise1_state", state_out, ST_IDLE);
    check("noise1_count", trig_count, exp_tc);
    arm_pulse();
    samp(1'b1, 95);
    for (int i = 0; i < 20; i++) samp(1'b1, (i % 2 == 0) ? 105 : 95);
    check("noise2_state", state_out, ST_WAIT);
    check("noise2_count", trig_count, exp_tc);
    samp(1'b1, 85);
    expect_trig(105);
    samp(1'b1, 105);
    for (int i = 0; i < 4; i++) samp(1'b1, 95);
    check("noise3_count", trig_count, exp_tc);
    check("noise3_state", state_out, ST_IDLE);

    // Long pre-trigger: a crossing during PRE must not trigger.
    set_cfg(100, 10, DIR_RISING, 16, 2, 0, 1'b0);
    arm_pulse();
    for (int i = 0; i < 16; i++) begin
      samp(1'b1, (i == 4) ? 150 : 0);
      if (i == 4) check("pre_cross_state", state_out, ST_PRE);
    end
    check("pre_done_state", state_out, ST_WAIT);
    check("pre_cross_count", trig_count, exp_tc);
    samp(1'b1, 50);
    expect_trig(150);
    samp(1'b1, 150);
    for (int i = 0; i < 3; i++) samp(1'b1, 0);
    check("pre_trig_count", trig_count, exp_tc);

    // Auto re-arm against a 64-sample square wave: one trigger per period, 21-cycle holdoff.
    set_cfg(0, 10, DIR_RISING, 4, 8, 20, 1'b1);
    arm_pulse();
    run = 0; first_run = 0; hold_total = 0;
    for (int k = 0; k < 256; k++) begin
      if (k % 64 == 32) expect_trig(1000);
      samp(1'b1, (k % 64 < 32) ? -1000 : 1000);
      if (state_out == ST_HOLDOFF) begin
        hold_total++;
        run++;
      end else begin
        if (run > 0 && first_run == 0) first_run = run;
        run = 0;
      end
    end
    check("auto_trig_count", trig_count, exp_tc);
    check("auto_holdoff_run", first_run, 21);
    check("auto_holdoff_total", hold_total, 84);
    s_axis_tvalid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("auto_abort_state", state_out, ST_IDLE);

    // force_trig together with a qualifying sample counts once.
    set_cfg(100, 10, DIR_RISING, 1, 1, 0, 1'b0);
    arm_pulse();
    samp(1'b1, 0);
    force_trig = 1'b1;
    expect_trig(150);
    samp(1'b1, 150);
    force_trig = 1'b0;
    samp(1'b1, 0);
    samp(1'b0, 0);
    check("force_qual_count", trig_count, exp_tc);
    check("force_qual_done", done, 1);
    check("force_qual_state", state_out, ST_IDLE);

    // Falling direction, 50% valid; invalid cycles carry data that would trigger if counted.
    set_cfg(-100, 10, DIR_FALLING, 3, 4, 0, 1'b0);
    arm_pulse();
    valid_cnt = 0;
    t6 = '{0, 0, 0, 0, -95, -105, -50, -50};
    for (int j = 0; j < 8; j++) begin
      if (j == 5) expect_trig(-105);
      samp(1'b1, t6[j]);
      samp(1'b0, -500);
      if (j == 1) check("fall_pre_hold", state_out, ST_PRE);
    end
    check("fall_state", state_out, ST_POST);
    check("fall_valid_outputs", valid_cnt, 8);
    check("fall_trig_count", trig_count, exp_tc);
    aresetn = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = W'(-50);
    tick();
    check("midrst_state", state_out, ST_IDLE);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_pulse", trig_pulse, 0);
    check("midrst_count", trig_count, 0);
    check("midrst_mvalid", m_axis_tvalid, 0);
    aresetn = 1'b1;
    s_axis_tvalid = 1'b0;
    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
